// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, LSB first, one bit per clock.
// Optional saturation when the macro SERIAL_SUB_SAT_EN is defined (d forced to 0 on a final borrow).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CW = $clog2(WIDTH + 1);

    // state | meaning
    // IDLE  | waiting for start, last result held on d/bo
    // RUN   | one operand bit pair consumed per clock
    // DONE  | d/bo final for this single cycle; start here chains the next op
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sa, sb;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             x, y, diff, bout, last;

    always_comb begin
        x    = sa[0];
        y    = sb[0];
        diff = x ^ y ^ borrow;
        bout = (~x & y) | (~(x ^ y) & borrow);
        last = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bo     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    borrow <= bout;
                    // Counter stops at WIDTH on the last bit, which still fits in CW bits.
                    cnt    <= cnt + CW'(1);
                    d      <= {diff, d[WIDTH-1:1]};
                    if (last) begin
                        bo <= bout;
`ifdef SERIAL_SUB_SAT_EN
                        if (bout) d <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed steps, scoreboard queue, immediate assertions.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, bo;
    logic [W-1:0] d;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [8:0] sb_q[$];
    logic [8:0] last_exp = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .bo(bo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] r;
        r = {1'b0, x} - {1'b0, y};
`ifdef SERIAL_SUB_SAT_EN
        if (r[8]) r[7:0] = 8'h00;
`endif
        return r;
    endfunction

    // Scoreboard consumer plus per-cycle busy/done exclusivity check.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_excl", {31'b0, busy & done}, 32'h0);
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    check("d", {24'b0, d}, {24'b0, e[7:0]});
                    check("bo", {31'b0, bo}, {31'b0, e[8]});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        start = 1'b1;
        a = x;
        b = y;
        last_exp = model(x, y);
        sb_q.push_back(last_exp);
    endtask

    // Called right after the accepting edge has been passed (at the following negedge).
    task automatic finish_op();
        int n;
        n = 0;
        while (!done && n < W + 5) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'b0, done}, 32'h1);
        check("latency", n, W);
    endtask

    task automatic do_op(input logic [7:0] x, input logic [7:0] y);
        int n;
        @(negedge clk);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        issue(x, y);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'h1);
        finish_op();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", {31'b0, done}, 32'h1);
    endtask

    initial begin
        time t1, t2;
        int  dc;
        logic [7:0] cv[6];
        cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

        // Reset state.
        #12;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_d", {24'b0, d}, 32'h0);
        check("rst_bo", {31'b0, bo}, 32'h0);

        // First start accepted on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h05, 8'h03);
        @(negedge clk);
        start = 1'b0;
        check("first_accept", {31'b0, busy}, 32'h1);
        finish_op();

        do_op(8'h03, 8'h05);
        do_op(8'h00, 8'hFF);
        do_op(8'hAA, 8'hAA);

        // Result held in IDLE.
        repeat (3) @(negedge clk);
        check("hold_d", {24'b0, d}, {24'b0, last_exp[7:0]});
        check("hold_bo", {31'b0, bo}, {31'b0, last_exp[8]});
        check("idle_busy", {31'b0, busy}, 32'h0);

        // Back-to-back with start held high and operands disturbed during RUN.
        @(negedge clk);
        issue(8'h11, 8'h22);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h01;
        wait_done();
        t1 = $time;
        issue(8'h40, 8'h0F);
        @(negedge clk);
        a = 8'h00;
        b = 8'h99;
        wait_done();
        t2 = $time;
        start = 1'b0;
        check("b2b_period", 32'((t2 - t1) / 10), W + 1);

        // Asynchronous reset mid-RUN while bit 4 is in progress.
        repeat (2) @(negedge clk);
        issue(8'h5A, 8'h3C);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_d", {24'b0, d}, 32'h0);
        check("abort_bo", {31'b0, bo}, 32'h0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dc = done_cnt;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", dc, done_cnt);
        do_op(8'hC8, 8'h37);

        // Corner grid followed by random pairs, chained back-to-back.
        @(negedge clk);
        issue(cv[0], cv[0]);
        for (int i = 1; i < 36; i++) begin
            wait_done();
            issue(cv[i / 6], cv[i % 6]);
        end
        for (int i = 0; i < 1200; i++) begin
            wait_done();
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        wait_done();
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
